// File: rtl/prim_calc_multi_pkg.sv
// Shared types and constants for the multi-digit primitive calculator.
//   state_t   : entry/display FSM states
//   op_t      : operation codes, cycled by the encoder in ENTER_OP
//   HEX_FONT  : seven-segment glyphs for nibbles 0..F (segments a..g on bits 0..6)
//   op_inc/op_dec : modulo-N_OPS stepping of the operation code
package prim_calc_pkg;

    typedef enum logic [1:0] {
        ENTER_A     = 2'd0,
        ENTER_B     = 2'd1,
        ENTER_OP    = 2'd2,
        SHOW_RESULT = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5
    } op_t;

    localparam int N_OPS = 6;

    localparam logic [6:0] BLANK = 7'h00;

    localparam logic [6:0] HEX_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic op_t op_inc(input op_t op);
        if (op == op_t'(N_OPS - 1)) begin
            return OP_ADD;
        end
        return op_t'(op + 3'd1);
    endfunction

    function automatic op_t op_dec(input op_t op);
        if (op == OP_ADD) begin
            return op_t'(N_OPS - 1);
        end
        return op_t'(op - 3'd1);
    endfunction

endpackage

// File: rtl/prim_calc_multi_if.sv
// Pad-side signal bundle of the calculator.
//   select, restart        : push buttons (raw, asynchronous)
//   rotary_a, rotary_b     : quadrature encoder channels (raw, asynchronous)
//   seven_segment_out      : segments a..g, active high
//   seven_segment_digit    : one-hot digit enable, active high
//   led_flag               : status flag of the shown result
//   sync                   : one-cycle pulse at the start of each refresh frame
//   result_o               : last computed result
// master = the pad side (drives buttons/encoder), slave = the calculator.
interface prim_calc_multi_if #(
    parameter int WIDTH      = 8,
    parameter int NUM_DIGITS = 2
);
    logic                  select;
    logic                  restart;
    logic                  rotary_a;
    logic                  rotary_b;
    logic [6:0]            seven_segment_out;
    logic [NUM_DIGITS-1:0] seven_segment_digit;
    logic                  led_flag;
    logic                  sync;
    logic [WIDTH-1:0]      result_o;

    modport master (
        output select, restart, rotary_a, rotary_b,
        input  seven_segment_out, seven_segment_digit, led_flag, sync, result_o
    );

    modport slave (
        input  select, restart, rotary_a, rotary_b,
        output seven_segment_out, seven_segment_digit, led_flag, sync, result_o
    );
endinterface

// File: rtl/prim_calc_multi_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and press pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw button level
//   press      : one-cycle pulse when an accepted 0->1 transition occurs
// A new level is accepted only after CYCLES consecutive synchronised samples
// that differ from the currently accepted level; any sample that matches the
// accepted level restarts the count, so short glitches are swallowed.
import prim_calc_pkg::*;

module prim_calc_debounce #(
    parameter int CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic press
);
    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic             meta_reg;
    logic             sync_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg  <= 1'b0;
            sync_reg  <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            meta_reg  <= din;
            sync_reg  <= meta_reg;
            press_reg <= 1'b0;
            if (sync_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(CYCLES - 1)) begin
                // this is the CYCLES-th differing sample: accept it
                level_reg <= sync_reg;
                cnt_reg   <= '0;
                press_reg <= sync_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/prim_calc_multi.sv
// Multi-digit primitive calculator.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pad bundle (buttons, encoder, display, flag, sync, result)
// Operands A and B and the operation are dialled in with a quadrature encoder;
// select advances ENTER_A -> ENTER_B -> ENTER_OP -> SHOW_RESULT -> ENTER_A,
// the last transition chaining the result into A. restart clears everything.
// The active value is shown in hex on a multiplexed seven-segment display.
import prim_calc_pkg::*;

module prim_calc_multi #(
    parameter int WIDTH           = 8,
    parameter int NUM_DIGITS      = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REFRESH_DIV     = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    prim_calc_multi_if.slave       bus
);
    localparam int NIBBLES = (WIDTH + 3) / 4;
    localparam int PAD_W   = NUM_DIGITS * 4;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    generate
        if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
            $error("prim_calc_multi: WIDTH must be in 4..16");
        end
        if (NUM_DIGITS < NIBBLES) begin : g_bad_digits
            $error("prim_calc_multi: NUM_DIGITS too small for WIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Buttons
    // ------------------------------------------------------------------
    logic sel_press;
    logic rst_press;

    prim_calc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_sel_db (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.select),
        .press (sel_press)
    );

    prim_calc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.restart),
        .press (rst_press)
    );

    // ------------------------------------------------------------------
    // Quadrature decoder
    // {a,b} = 00,10,11,01 maps to position 0,1,2,3 via pos = {b, a^b}.
    // Position delta +1 is CW, -1 (i.e. 3) is CCW, 2 means both bits moved
    // and is dropped.
    // ------------------------------------------------------------------
    logic [1:0] rot_meta_reg;
    logic [1:0] rot_sync_reg;
    logic [1:0] rot_prev_reg;
    logic [1:0] pos_cur;
    logic [1:0] pos_prev;
    logic [1:0] pos_delta;
    logic       step_up;
    logic       step_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_meta_reg <= 2'b00;
            rot_sync_reg <= 2'b00;
            rot_prev_reg <= 2'b00;
        end else begin
            rot_meta_reg <= {bus.rotary_a, bus.rotary_b};
            rot_sync_reg <= rot_meta_reg;
            rot_prev_reg <= rot_sync_reg;
        end
    end

    assign pos_cur   = {rot_sync_reg[0], rot_sync_reg[1] ^ rot_sync_reg[0]};
    assign pos_prev  = {rot_prev_reg[0], rot_prev_reg[1] ^ rot_prev_reg[0]};
    assign pos_delta = pos_cur - pos_prev;
    assign step_up   = (pos_delta == 2'd1);
    assign step_dn   = (pos_delta == 2'd3);

    // ------------------------------------------------------------------
    // FSM and ALU
    // ------------------------------------------------------------------
    state_t           state_reg,  state_next;
    logic [WIDTH-1:0] a_reg,      a_next;
    logic [WIDTH-1:0] b_reg,      b_next;
    logic [WIDTH-1:0] result_reg, result_next;
    op_t              op_reg,     op_next;
    logic             flag_reg,   flag_next;

    logic [WIDTH-1:0] a_stepped;
    logic [WIDTH-1:0] b_stepped;
    op_t              op_stepped;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_flag;
    logic [WIDTH:0]     add_full;
    logic [2*WIDTH-1:0] mul_full;

    always_comb begin
        a_stepped  = a_reg;
        b_stepped  = b_reg;
        op_stepped = op_reg;
        if (step_up) begin
            a_stepped  = a_reg + 1'b1;
            b_stepped  = b_reg + 1'b1;
            op_stepped = op_inc(op_reg);
        end else if (step_dn) begin
            a_stepped  = a_reg - 1'b1;
            b_stepped  = b_reg - 1'b1;
            op_stepped = op_dec(op_reg);
        end
    end

    // The operation code used is the one after this cycle's encoder step,
    // so a step and a select landing together take effect in that order.
    assign add_full = {1'b0, a_reg} + {1'b0, b_reg};
    assign mul_full = (2*WIDTH)'(a_reg) * (2*WIDTH)'(b_reg);

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        case (op_stepped)
            OP_ADD: begin
                alu_res  = add_full[WIDTH-1:0];
                alu_flag = add_full[WIDTH];
            end
            OP_SUB: begin
                alu_res  = a_reg - b_reg;
                alu_flag = (a_reg < b_reg);
            end
            OP_MUL: begin
                alu_res  = mul_full[WIDTH-1:0];
                alu_flag = |mul_full[2*WIDTH-1:WIDTH];
            end
            OP_AND: begin
                alu_res  = a_reg & b_reg;
                alu_flag = ((a_reg & b_reg) == '0);
            end
            OP_OR: begin
                alu_res  = a_reg | b_reg;
                alu_flag = ((a_reg | b_reg) == '0);
            end
            OP_XOR: begin
                alu_res  = a_reg ^ b_reg;
                alu_flag = ((a_reg ^ b_reg) == '0);
            end
            default: begin
                alu_res  = '0;
                alu_flag = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        op_next     = op_reg;
        result_next = result_reg;
        flag_next   = flag_reg;

        case (state_reg)
            ENTER_A: begin
                a_next = a_stepped;
                if (sel_press) begin
                    state_next = ENTER_B;
                end
            end
            ENTER_B: begin
                b_next = b_stepped;
                if (sel_press) begin
                    state_next = ENTER_OP;
                end
            end
            ENTER_OP: begin
                op_next = op_stepped;
                if (sel_press) begin
                    state_next  = SHOW_RESULT;
                    result_next = alu_res;
                    flag_next   = alu_flag;
                end
            end
            SHOW_RESULT: begin
                if (sel_press) begin
                    state_next = ENTER_A;
                    a_next     = result_reg;
                    b_next     = '0;
                    flag_next  = 1'b0;
                end
            end
            default: begin
                state_next = ENTER_A;
            end
        endcase

        // restart overrides any select or step seen in the same cycle
        if (rst_press) begin
            state_next  = ENTER_A;
            a_next      = '0;
            b_next      = '0;
            op_next     = OP_ADD;
            result_next = '0;
            flag_next   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ENTER_A;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= OP_ADD;
            result_reg <= '0;
            flag_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            op_reg     <= op_next;
            result_reg <= result_next;
            flag_reg   <= flag_next;
        end
    end

    // ------------------------------------------------------------------
    // Display refresh
    // ------------------------------------------------------------------
    logic [REF_W-1:0] ref_cnt_reg, ref_cnt_next;
    logic [IDX_W-1:0] idx_reg,     idx_next;
    logic             ref_wrap;
    logic             frame_wrap;

    always_comb begin
        ref_wrap     = (ref_cnt_reg == REF_W'(REFRESH_DIV - 1));
        ref_cnt_next = ref_wrap ? '0 : ref_cnt_reg + 1'b1;
        frame_wrap   = ref_wrap && (idx_reg == IDX_W'(NUM_DIGITS - 1));
        idx_next     = idx_reg;
        if (ref_wrap) begin
            idx_next = frame_wrap ? '0 : idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_reg <= '0;
            idx_reg     <= '0;
        end else begin
            ref_cnt_reg <= ref_cnt_next;
            idx_reg     <= idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Display mux
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] shown_value;
    logic [PAD_W-1:0] shown_pad;
    logic [6:0]       digit_seg [NUM_DIGITS];

    always_comb begin
        case (state_reg)
            ENTER_A:     shown_value = a_reg;
            ENTER_B:     shown_value = b_reg;
            ENTER_OP:    shown_value = WIDTH'(op_reg);
            SHOW_RESULT: shown_value = result_reg;
            default:     shown_value = '0;
        endcase
    end

    assign shown_pad = PAD_W'(shown_value);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi >= NIBBLES) begin : g_unused
                assign digit_seg[gi] = BLANK;
            end else if (gi == 0) begin : g_lsd
                assign digit_seg[gi] = HEX_FONT[shown_pad[3:0]];
            end else begin : g_upper
                // op index is a single digit; upper digits are dark then
                assign digit_seg[gi] = (state_reg == ENTER_OP) ? BLANK
                                     : HEX_FONT[shown_pad[gi*4 +: 4]];
            end
        end
    endgenerate

    // Output registers are loaded from the next digit index so that the
    // segment pattern, the digit enable and sync all change on the same edge.
    logic [6:0]            seg_reg;
    logic [NUM_DIGITS-1:0] digit_reg;
    logic                  sync_reg;
    logic                  led_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg   <= 7'h3F;
            digit_reg <= NUM_DIGITS'(1);
            sync_reg  <= 1'b0;
            led_reg   <= 1'b0;
        end else begin
            seg_reg   <= digit_seg[idx_next];
            digit_reg <= NUM_DIGITS'(1) << idx_next;
            sync_reg  <= frame_wrap;
            led_reg   <= (state_next == SHOW_RESULT) && flag_next;
        end
    end

    assign bus.seven_segment_out   = seg_reg;
    assign bus.seven_segment_digit = digit_reg;
    assign bus.sync                = sync_reg;
    assign bus.led_flag            = led_reg;
    assign bus.result_o            = result_reg;

endmodule

// File: tb/tb_prim_calc_multi.sv
// Directed bench for prim_calc_multi (WIDTH=8, two digits, short debounce
// and refresh). Operands are dialled in through the encoder pins; values are
// observed on the multiplexed display, result_o and led_flag.
module tb_prim_calc_multi;

    localparam int WIDTH = 8;
    localparam int ND    = 2;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   enc_pos;

    logic [6:0] font [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    prim_calc_multi_if #(.WIDTH(WIDTH), .NUM_DIGITS(ND)) bus ();

    prim_calc_multi #(
        .WIDTH           (WIDTH),
        .NUM_DIGITS      (ND),
        .DEBOUNCE_CYCLES (4),
        .REFRESH_DIV     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-18s got 0x%0h", tag, got);
        end else begin
            $display("FAIL %-18s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // encoder position 0..3 corresponds to {a,b} = 00,10,11,01
    task automatic drive_enc();
        case (enc_pos)
            0: {bus.rotary_a, bus.rotary_b} = 2'b00;
            1: {bus.rotary_a, bus.rotary_b} = 2'b10;
            2: {bus.rotary_a, bus.rotary_b} = 2'b11;
            default: {bus.rotary_a, bus.rotary_b} = 2'b01;
        endcase
        tick(4);
    endtask

    task automatic step_cw(input int n);
        for (int i = 0; i < n; i++) begin
            enc_pos = (enc_pos + 1) % 4;
            drive_enc();
        end
    endtask

    task automatic step_ccw(input int n);
        for (int i = 0; i < n; i++) begin
            enc_pos = (enc_pos + 3) % 4;
            drive_enc();
        end
    endtask

    task automatic step_invalid();
        enc_pos = (enc_pos + 2) % 4;
        drive_enc();
    endtask

    task automatic press(input bit sel, input bit rst);
        bus.select  = sel;
        bus.restart = rst;
        tick(12);
        bus.select  = 1'b0;
        bus.restart = 1'b0;
        tick(12);
    endtask

    task automatic check_digits(input string tag, input logic [6:0] exp0, input logic [6:0] exp1);
        int n;
        n = 0;
        while (bus.seven_segment_digit !== 2'b01 && n < 64) begin
            tick(1);
            n++;
        end
        if (n >= 64) check({tag, "_d0_timeout"}, 0, 1);
        else         check({tag, "_d0"}, bus.seven_segment_out, exp0);
        n = 0;
        while (bus.seven_segment_digit !== 2'b10 && n < 64) begin
            tick(1);
            n++;
        end
        if (n >= 64) check({tag, "_d1_timeout"}, 0, 1);
        else         check({tag, "_d1"}, bus.seven_segment_out, exp1);
    endtask

    task automatic check_shown(input string tag, input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[3:0];
        hi = v[7:4];
        check_digits(tag, font[lo], font[hi]);
    endtask

    task automatic wait_sync(output int t, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        t  = 0;
        while (n < 64) begin
            tick(1);
            n++;
            if (bus.sync === 1'b1) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    initial begin
        int  t0;
        int  t1;
        bit  ok;
        int  n;

        cyc          = 0;
        n_checks     = 0;
        n_pass       = 0;
        enc_pos      = 0;
        rst_n        = 1'b0;
        bus.select   = 1'b0;
        bus.restart  = 1'b0;
        bus.rotary_a = 1'b0;
        bus.rotary_b = 1'b0;

        // reset state
        tick(3);
        check("rst_seg",    bus.seven_segment_out,   7'h3F);
        check("rst_digit",  bus.seven_segment_digit, 2'b01);
        check("rst_led",    bus.led_flag,            0);
        check("rst_sync",   bus.sync,                0);
        check("rst_result", bus.result_o,            0);
        rst_n = 1'b1;
        tick(2);

        // three CW steps -> A=3
        step_cw(3);
        check_shown("a_eq_3", 8'h03);

        // wrap down and back up
        press(1'b0, 1'b1);
        step_ccw(1);
        check_shown("a_wrap_ff", 8'hFF);
        step_cw(1);
        check_shown("a_wrap_00", 8'h00);

        // both encoder bits changing together is ignored
        step_invalid();
        check_shown("invalid_1", 8'h00);
        step_invalid();
        check_shown("invalid_2", 8'h00);

        // 200 + 100 = 0x2C with carry, then chain into A
        step_ccw(56);
        check_shown("a_eq_200", 8'hC8);
        press(1'b1, 1'b0);
        step_cw(100);
        check_shown("b_eq_100", 8'h64);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("add_result", bus.result_o, 8'h2C);
        check("add_led",    bus.led_flag, 1);
        check_shown("add_shown", 8'h2C);
        press(1'b1, 1'b0);
        check("chain_led",  bus.led_flag, 0);
        check_shown("chain_a", 8'h2C);
        check("chain_result", bus.result_o, 8'h2C);

        // 5 - 7 = 0xFE with borrow
        press(1'b0, 1'b1);
        check("restart_result", bus.result_o, 0);
        step_cw(5);
        press(1'b1, 1'b0);
        step_cw(7);
        press(1'b1, 1'b0);
        step_cw(1);
        press(1'b1, 1'b0);
        check("sub_result", bus.result_o, 8'hFE);
        check("sub_led",    bus.led_flag, 1);

        // 16 * 16 = 0x100 -> low byte 0, high half nonzero
        press(1'b0, 1'b1);
        step_cw(16);
        press(1'b1, 1'b0);
        step_cw(16);
        press(1'b1, 1'b0);
        step_cw(2);
        check_digits("op_mul", 7'h5B, 7'h00);
        press(1'b1, 1'b0);
        check("mul_result", bus.result_o, 8'h00);
        check("mul_led",    bus.led_flag, 1);

        // two-cycle select glitch is rejected
        press(1'b0, 1'b1);
        check("mul_led_clr", bus.led_flag, 0);
        step_cw(3);
        bus.select = 1'b1;
        tick(2);
        bus.select = 1'b0;
        tick(12);
        check_shown("glitch_a", 8'h03);
        step_cw(1);
        check_shown("glitch_a_step", 8'h04);

        // restart together with select in ENTER_B
        press(1'b1, 1'b0);
        step_cw(2);
        check_shown("b_eq_2", 8'h02);
        press(1'b1, 1'b1);
        check_shown("both_a0", 8'h00);
        step_cw(3);
        check_shown("both_a3", 8'h03);
        press(1'b1, 1'b0);
        check_shown("both_b0", 8'h00);
        press(1'b1, 1'b0);
        check_digits("both_op_add", 7'h3F, 7'h00);
        press(1'b1, 1'b0);
        check("add3_result", bus.result_o, 8'h03);
        check("add3_led",    bus.led_flag, 0);

        // refresh frame: 16 cycles, digit order 01,10,01
        wait_sync(t0, ok);
        if (!ok) check("sync_timeout_0", 0, 1);
        else     check("sync_digit_0", bus.seven_segment_digit, 2'b01);
        tick(8);
        check("frame_digit_1", bus.seven_segment_digit, 2'b10);
        check("frame_sync_lo", bus.sync, 0);
        wait_sync(t1, ok);
        if (!ok) check("sync_timeout_1", 0, 1);
        else begin
            check("sync_period",  t1 - t0, 16);
            check("sync_digit_2", bus.seven_segment_digit, 2'b01);
        end

        // asynchronous reset mid-frame
        n = 0;
        while (bus.seven_segment_digit !== 2'b10 && n < 64) begin
            tick(1);
            n++;
        end
        if (n >= 64) check("midrst_timeout", 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_digit",  bus.seven_segment_digit, 2'b01);
        check("midrst_sync",   bus.sync,                0);
        check("midrst_seg",    bus.seven_segment_out,   7'h3F);
        check("midrst_result", bus.result_o,            0);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
